lsb_mem_sequencer: RTL and testbench
====================================

Name: lsb_mem_sequencer

Overview:
- Sits between the load/store buffer and the memory controller's byte-wide LSB port.
- Accepts one byte, halfword or word load/store per request.
- Splits each request into sequential single-byte memory transactions in little-endian order, then assembles and sign- or zero-extends load data.
- Returns a single 32-bit response per request and supports flush of in-flight loads.

Parameters:
ADDR_W, 32, address width for request and memory addresses

Ports:
clk_in  input  1  system clock
rst_in  input  1  reset, asynchronous, active-low
rdy_in  input  1  global ready; low freezes the block
flush_in  input  1  pipeline flush (mispredict recovery)
req_valid_in  input  1  request from LSB valid
req_ready_out  output  1  block can accept a request
req_wr_in  input  1  1 = store, 0 = load
req_size_in  input  2  00 byte, 01 half, 10 word, 11 treated as word
req_sign_in  input  1  1 = sign-extend load result
req_addr_in  input  ADDR_W  byte address, any alignment
req_wdata_in  input  32  store data, byte i = bits [8i+7:8i]
resp_valid_out  output  1  one-cycle response strobe
resp_data_out  output  32  extended load data; 0 for stores
mem_req_out  output  1  one-cycle byte-transaction strobe to the memory controller
mem_wr_out  output  1  1 = byte write
mem_addr_out  output  ADDR_W  byte address
mem_wdata_out  output  8  byte to write
mem_done_in  input  1  memory controller byte transaction complete
mem_rdata_in  input  8  read byte, valid with mem_done_in

Behaviour:
- Reset (rst_in low, asynchronous):
  - State = IDLE.
  - req_ready_out = 1.
  - resp_valid_out = 0, resp_data_out = 0.
  - mem_req_out = 0, mem_wr_out = 0, mem_addr_out = 0, mem_wdata_out = 0.
  - Byte index = 0, drop flag = 0.
  - Reset mid-transaction abandons it with no response.
- FSM states are IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - req_ready_out = 1.
  - Request is accepted on a clock edge where req_valid_in = 1 and flush_in = 0.
  - On accept, latch wr, size, sign, addr and wdata; set byte count N = 1/2/4; set index = 0; go to ISSUE.
- ISSUE:
  - mem_req_out = 1 for exactly one cycle.
  - mem_addr_out = addr + index (modulo 2^ADDR_W; wraps past 0xFFFFFFFF).
  - mem_wr_out = wr.
  - mem_wdata_out = wdata byte[index] for stores, 0 for loads.
  - Next state is WAIT.
- WAIT:
  - mem_req_out = 0; mem_addr_out, mem_wr_out and mem_wdata_out hold.
  - On mem_done_in = 1, a load captures mem_rdata_in into assembly byte[index].
  - If index = N-1, or the drop flag is set, go to RESP. Otherwise index++ and go to ISSUE.
  - mem_done_in outside WAIT is ignored.
- RESP:
  - resp_valid_out = 1 for one cycle, unless the drop flag is set (then 0).
  - Load result:
    - byte: {24 x (sign & b0[7]), b0}.
    - half: {16 x (sign & b1[7]), b1, b0}.
    - word: raw 32 bits.
  - Store result: resp_data_out = 0.
  - Clear the drop flag; go to IDLE.
- Latency (zero-wait memory with done one cycle after the strobe): accept at edge T, response visible after edge T+2N+1.
  - Byte: 3 cycles. Half: 5 cycles. Word: 9 cycles.
- flush_in:
  - IDLE: request not accepted.
  - ISSUE/WAIT: set the drop flag. The current byte is still completed (strobe issued, done awaited) so the memory controller stays in step, but no further bytes are issued.
  - RESP: response suppressed.
  - Stores already partially written are not undone.
- rdy_in low:
  - No state, index or register changes.
  - mem_req_out and resp_valid_out are gated to 0.
  - mem_done_in is ignored.
  - A pending strobe or response is emitted once rdy_in returns high.
- Simultaneous flush_in and mem_done_in in WAIT: data is captured, the drop flag is set, and the block goes to RESP with the response suppressed.
- req_ready_out = 0 in every state except IDLE.

Test Plan:
- Word load, addr 0x1000, memory bytes 0x11, 0x22, 0x33, 0x84 -> mem strobes at 0x1000..0x1003; resp_data_out = 0x84332211; 9-cycle latency with 1-cycle done.
- Signed half load, addr 0x2001, bytes 0xFE, 0x80 -> strobes at 0x2001, 0x2002; resp = 0xFFFF80FE. Repeat with req_sign_in = 0 -> resp = 0x000080FE.
- Byte store, addr 0x30, wdata 0xDEADBEEF -> single strobe with mem_wr_out = 1, mem_wdata_out = 0xEF; resp_valid_out pulse with data 0.
- Word load at addr 0xFFFFFFFE -> strobes at 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000, 0x00000001.
- Word load, flush_in pulsed while waiting on byte 1 -> byte 1 done is still consumed; no strobe for bytes 2/3; no resp_valid_out; req_ready_out = 1 the cycle after RESP.
- rdy_in low for 3 cycles while in ISSUE -> mem_req_out stays 0 during the stall, then one strobe after rdy_in rises. Async reset during WAIT -> all outputs zero immediately, req_ready_out = 1.

Source files
------------

// File: rtl/lsb_mem_sequencer.sv
// Byte-serial load/store sequencer between the load/store buffer and a byte-wide memory port.
// Splits byte/half/word requests into little-endian byte transactions and extends load data.
module lsb_mem_sequencer #(
  parameter int ADDR_W = 32
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              flush_in,
  input  logic              req_valid_in,
  output logic              req_ready_out,
  input  logic              req_wr_in,
  input  logic [1:0]        req_size_in,
  input  logic              req_sign_in,
  input  logic [ADDR_W-1:0] req_addr_in,
  input  logic [31:0]       req_wdata_in,
  output logic              resp_valid_out,
  output logic [31:0]       resp_data_out,
  output logic              mem_req_out,
  output logic              mem_wr_out,
  output logic [ADDR_W-1:0] mem_addr_out,
  output logic [7:0]        mem_wdata_out,
  input  logic              mem_done_in,
  input  logic [7:0]        mem_rdata_in
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t            state, state_nxt;
  logic              wr_q, sign_q, drop_q, resp_valid_q;
  logic [1:0]        size_q, idx_q, last_idx;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q, asm_q, resp_data_q, result;
  logic              last_byte;

  always_comb begin
    last_idx = 2'd3;
    case (size_q)
      2'b00:   last_idx = 2'd0;
      2'b01:   last_idx = 2'd1;
      default: last_idx = 2'd3;
    endcase
  end

  // A flush seen alongside the final done still ends the request here.
  assign last_byte = (idx_q == last_idx) || drop_q || flush_in;

  always_comb begin
    result = asm_q;
    case (size_q)
      2'b00:   result = {{24{sign_q & asm_q[7]}}, asm_q[7:0]};
      2'b01:   result = {{16{sign_q & asm_q[15]}}, asm_q[15:0]};
      default: result = asm_q;
    endcase
    if (wr_q) result = '0;
  end

  always_comb begin
    state_nxt = state;
    if (rdy_in) begin
      case (state)
        IDLE:    if (req_valid_in && !flush_in) state_nxt = ISSUE;
        ISSUE:   state_nxt = WAIT;
        WAIT:    if (mem_done_in) state_nxt = last_byte ? RESP : ISSUE;
        RESP:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Response is registered on leaving RESP and held while rdy_in is low.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state        <= IDLE;
      wr_q         <= 1'b0;
      sign_q       <= 1'b0;
      size_q       <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      idx_q        <= '0;
      drop_q       <= 1'b0;
      asm_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
    end else if (rdy_in) begin
      state        <= state_nxt;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      case (state)
        IDLE: begin
          if (req_valid_in && !flush_in) begin
            wr_q    <= req_wr_in;
            sign_q  <= req_sign_in;
            size_q  <= req_size_in;
            addr_q  <= req_addr_in;
            wdata_q <= req_wdata_in;
            idx_q   <= '0;
            asm_q   <= '0;
            drop_q  <= 1'b0;
          end
        end
        ISSUE: begin
          if (flush_in) drop_q <= 1'b1;
        end
        WAIT: begin
          if (flush_in) drop_q <= 1'b1;
          if (mem_done_in) begin
            if (!wr_q) asm_q[{idx_q, 3'b000} +: 8] <= mem_rdata_in;
            if (!last_byte) idx_q <= idx_q + 2'd1;
          end
        end
        RESP: begin
          resp_valid_q <= !drop_q && !flush_in;
          resp_data_q  <= (!drop_q && !flush_in) ? result : '0;
          drop_q       <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign req_ready_out  = (state == IDLE);
  assign mem_req_out    = rdy_in && (state == ISSUE);
  assign mem_wr_out     = wr_q;
  assign mem_addr_out   = addr_q + ADDR_W'(idx_q);
  assign mem_wdata_out  = wr_q ? wdata_q[{idx_q, 3'b000} +: 8] : '0;
  assign resp_valid_out = resp_valid_q && rdy_in;
  assign resp_data_out  = resp_data_q;

endmodule

// File: tb/tb_lsb_mem_sequencer.sv
// Self-checking bench for lsb_mem_sequencer: byte-level memory responder plus a
// request-level model of expected byte transactions, responses and latency.
module tb_lsb_mem_sequencer;
  localparam int ADDR_W = 32;

  logic        clk = 1'b0, rst_n = 1'b1, rdy = 1'b1, flush = 1'b0;
  logic        req_valid = 1'b0, req_wr = 1'b0, req_sign = 1'b0;
  logic [1:0]  req_size = '0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        req_ready, resp_valid;
  logic [31:0] resp_data;
  logic        mem_req, mem_wr;
  logic [31:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_done = 1'b0;
  logic [7:0]  mem_rdata = '0;

  lsb_mem_sequencer #(.ADDR_W(ADDR_W)) dut (
    .clk_in(clk), .rst_in(rst_n), .rdy_in(rdy), .flush_in(flush),
    .req_valid_in(req_valid), .req_ready_out(req_ready), .req_wr_in(req_wr),
    .req_size_in(req_size), .req_sign_in(req_sign), .req_addr_in(req_addr),
    .req_wdata_in(req_wdata), .resp_valid_out(resp_valid), .resp_data_out(resp_data),
    .mem_req_out(mem_req), .mem_wr_out(mem_wr), .mem_addr_out(mem_addr),
    .mem_wdata_out(mem_wdata), .mem_done_in(mem_done), .mem_rdata_in(mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [31:0] a;
    logic        w;
    logic [7:0]  d;
  } strobe_t;

  strobe_t     exp_q[$];
  logic [31:0] exp_resp[$];
  logic [31:0] addr_log[$];
  logic [7:0]  mem [logic [31:0]];
  int          n_pass = 0, n_total = 0;
  int          strobe_cnt = 0, resp_cnt = 0, resp_cyc = 0;
  logic [31:0] last_resp = '0;
  int          rdy_mode = 0;
  int          mem_dly_max = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic fail_now(input string name, input string msg);
    n_total++;
    $display("FAIL %s: %s", name, msg);
  endtask

  function automatic logic [7:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a[7:0] ^ a[15:8] ^ a[31:24] ^ 8'hA5;
  endfunction

  // rdy driver: 0 = high, 1 = random, 2 = held low
  initial forever begin
    @(posedge clk); #1;
    case (rdy_mode)
      0:       rdy = 1'b1;
      1:       rdy = ($urandom_range(0, 3) != 0);
      default: rdy = 1'b0;
    endcase
  end

  // Memory responder and strobe checker
  initial forever begin
    @(negedge clk);
    if (mem_req === 1'b1) begin
      strobe_t s, e;
      int      d, g;
      s.a = mem_addr; s.w = mem_wr; s.d = mem_wdata;
      strobe_cnt++;
      addr_log.push_back(s.a);
      if (exp_q.size() == 0) fail_now("strobe_unexpected", $sformatf("got strobe addr 0x%0h, required none", s.a));
      else begin
        e = exp_q.pop_front();
        check("strobe", {s, req_ready}, {e, 1'b0});
      end
      d = $urandom_range(0, mem_dly_max);
      @(posedge clk); #1;
      repeat (d) begin @(posedge clk); #1; end
      mem_done  = 1'b1;
      mem_rdata = s.w ? 8'h00 : mem_rd(s.a);
      g = 0;
      do begin @(posedge clk); g++; end while (rdy !== 1'b1 && g < 1000);
      if (s.w) mem[s.a] = s.d;
      #1;
      mem_done  = 1'b0;
      mem_rdata = '0;
    end
  end

  // Response checker
  initial forever begin
    @(negedge clk);
    if (resp_valid === 1'b1) begin
      resp_cnt++;
      resp_cyc  = cyc;
      last_resp = resp_data;
      if (exp_resp.size() == 0) fail_now("resp_unexpected", $sformatf("got response 0x%0h, required none", resp_data));
      else check("resp_data", resp_data, exp_resp.pop_front());
    end
  end

  function automatic logic [31:0] model_result(input logic wr, input logic [1:0] size,
                                               input logic sign, input logic [31:0] addr);
    logic [31:0] v;
    logic [7:0]  b0, b1;
    if (wr) return 32'h0;
    b0 = mem_rd(addr);
    b1 = mem_rd(addr + 32'd1);
    if (size == 2'b00) begin
      v = {24'h0, b0};
      if (sign && b0 >= 8'h80) v = v | 32'hFFFFFF00;
    end else if (size == 2'b01) begin
      v = 32'(b0) + 32'(b1) * 256;
      if (sign && b1 >= 8'h80) v = v | 32'hFFFF0000;
    end else begin
      v = 0;
      for (int i = 0; i < 4; i++) v = v + (32'(mem_rd(addr + 32'(i))) << (8 * i));
    end
    return v;
  endfunction

  task automatic send(input logic wr, input logic [1:0] size, input logic sign,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input int nstrobe, input logic want_resp, input int stall, output int acc);
    int g;
    for (int i = 0; i < nstrobe; i++) begin
      strobe_t s;
      s.a = addr + 32'(i);
      s.w = wr;
      s.d = wr ? wdata[8*i +: 8] : 8'h00;
      exp_q.push_back(s);
    end
    if (want_resp) exp_resp.push_back(model_result(wr, size, sign, addr));
    @(posedge clk); #1;
    req_valid = 1'b1; req_wr = wr; req_size = size; req_sign = sign;
    req_addr = addr; req_wdata = wdata;
    g = 0;
    forever begin
      @(negedge clk);
      g++;
      if (req_ready === 1'b1 && rdy === 1'b1) break;
      if (g > 500) begin
        fail_now("accept_timeout", "request never accepted");
        break;
      end
    end
    if (stall > 0) rdy_mode = 2;
    @(posedge clk); #1;
    req_valid = 1'b0;
    acc = cyc;
  endtask

  task automatic wait_done(input int base_resp, input int acc, input int exp_lat);
    int g = 0;
    while (resp_cnt == base_resp && g < 500) begin @(negedge clk); #1; g++; end
    if (resp_cnt == base_resp) fail_now("resp_timeout", "no response within 500 cycles");
    else if (exp_lat > 0) check("latency", resp_cyc - acc, exp_lat);
    check("strobes_consumed", exp_q.size(), 0);
  endtask

  task automatic wait_strobes(input int target);
    int g = 0;
    while (strobe_cnt < target && g < 300) begin @(negedge clk); #1; g++; end
    if (strobe_cnt < target) fail_now("strobe_timeout", "expected strobe never issued");
  endtask

  task automatic pulse_flush();
    @(posedge clk); #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
  endtask

  task automatic wait_idle(input int base_resp);
    int g = 0;
    while (req_ready !== 1'b1 && g < 300) begin @(negedge clk); #1; g++; end
    if (req_ready !== 1'b1) fail_now("idle_timeout", "block never returned to idle");
    repeat (4) @(negedge clk);
    check("flush_no_resp", resp_cnt, base_resp);
    check("flush_strobes", exp_q.size(), 0);
    check("flush_ready", req_ready, 1'b1);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int acc, b_r, b_s, n, fl;
    logic rwr, rsign, rmode;
    logic [1:0] rsize;
    logic [31:0] raddr, rwdata;

    #1 rst_n = 1'b0;
    #2;
    check("reset_outs", {resp_valid, resp_data, mem_req, mem_wr, mem_addr, mem_wdata}, '0);
    check("reset_ready", req_ready, 1'b1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    mem[32'h1000] = 8'h11; mem[32'h1001] = 8'h22; mem[32'h1002] = 8'h33; mem[32'h1003] = 8'h84;
    b_r = resp_cnt;
    send(1'b0, 2'b10, 1'b0, 32'h1000, 32'h0, 4, 1'b1, 0, acc);
    wait_done(b_r, acc, 9);
    check("word_load_value", last_resp, 32'h84332211);
    n = addr_log.size();
    check("word_load_addrs", {addr_log[n-4], addr_log[n-3], addr_log[n-2], addr_log[n-1]},
          {32'h1000, 32'h1001, 32'h1002, 32'h1003});

    mem[32'h2001] = 8'hFE; mem[32'h2002] = 8'h80;
    b_r = resp_cnt;
    send(1'b0, 2'b01, 1'b1, 32'h2001, 32'h0, 2, 1'b1, 0, acc);
    wait_done(b_r, acc, 5);
    check("half_signed_value", last_resp, 32'hFFFF80FE);
    b_r = resp_cnt;
    send(1'b0, 2'b01, 1'b0, 32'h2001, 32'h0, 2, 1'b1, 0, acc);
    wait_done(b_r, acc, 5);
    check("half_unsigned_value", last_resp, 32'h000080FE);

    b_r = resp_cnt;
    send(1'b1, 2'b00, 1'b0, 32'h30, 32'hDEADBEEF, 1, 1'b1, 0, acc);
    wait_done(b_r, acc, 3);
    check("byte_store_resp", last_resp, 32'h0);
    check("byte_store_mem", mem_rd(32'h30), 8'hEF);

    b_r = resp_cnt;
    send(1'b0, 2'b11, 1'b0, 32'hFFFFFFFE, 32'h0, 4, 1'b1, 0, acc);
    wait_done(b_r, acc, 9);
    n = addr_log.size();
    check("wrap_addrs", {addr_log[n-4], addr_log[n-3], addr_log[n-2], addr_log[n-1]},
          {32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000000, 32'h00000001});

    b_r = resp_cnt; b_s = strobe_cnt;
    send(1'b0, 2'b10, 1'b0, 32'h4000, 32'h0, 2, 1'b0, 0, acc);
    wait_strobes(b_s + 2);
    pulse_flush();
    wait_idle(b_r);
    check("flush_strobe_count", strobe_cnt - b_s, 2);

    b_r = resp_cnt;
    send(1'b0, 2'b00, 1'b1, 32'h50, 32'h0, 1, 1'b1, 3, acc);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_no_strobe", mem_req, 1'b0);
    end
    rdy_mode = 0;
    wait_done(b_r, acc, 6);

    b_s = strobe_cnt;
    @(posedge clk); #1;
    req_valid = 1'b1; req_size = 2'b00; req_wr = 1'b0; flush = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    check("idle_flush_rejects", {req_ready, mem_req}, 2'b10);
    repeat (3) @(negedge clk);
    check("idle_flush_no_strobe", strobe_cnt, b_s);

    for (int it = 0; it < 60; it++) begin
      rwr    = $urandom_range(0, 1);
      rsize  = 2'($urandom_range(0, 3));
      rsign  = $urandom_range(0, 1);
      rwdata = $urandom;
      raddr  = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFC + 32'($urandom_range(0, 3)) : $urandom;
      n      = (rsize == 2'b00) ? 1 : (rsize == 2'b01) ? 2 : 4;
      mem_dly_max = $urandom_range(0, 2);
      rmode  = ($urandom_range(0, 2) == 0);
      fl     = -1;
      if (!rmode && $urandom_range(0, 3) == 0) fl = $urandom_range(0, n - 1);
      rdy_mode = rmode ? 1 : 0;
      b_r = resp_cnt; b_s = strobe_cnt;
      send(rwr, rsize, rsign, raddr, rwdata, (fl < 0) ? n : fl + 1, fl < 0, 0, acc);
      if (fl >= 0) begin
        wait_strobes(b_s + fl + 1);
        pulse_flush();
        wait_idle(b_r);
      end else begin
        wait_done(b_r, acc, (mem_dly_max == 0 && !rmode) ? 2 * n + 1 : 0);
      end
    end
    rdy_mode = 0;
    mem_dly_max = 0;
    repeat (2) @(posedge clk);

    b_r = resp_cnt; b_s = strobe_cnt;
    send(1'b0, 2'b10, 1'b0, 32'h6000, 32'h0, 1, 1'b0, 0, acc);
    wait_strobes(b_s + 1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_outs", {resp_valid, resp_data, mem_req, mem_wr, mem_addr, mem_wdata}, '0);
    check("async_rst_ready", req_ready, 1'b1);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("post_rst_strobes", strobe_cnt - b_s, 1);
    check("post_rst_no_resp", resp_cnt, b_r);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
